// File: rtl/div_hilo_ctrl.sv
// HI/LO register owner and launch/retire sequencer for the shared iterative
// divider; stalls HI/LO consumers and second divides while a divide is in flight.
module div_hilo_ctrl #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [2:0]        op_code,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              div_kill,
  output logic              stall,
  output logic [DATA_W-1:0] rd_val,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              div_start,
  output logic              div_signed,
  output logic [DATA_W-1:0] div_dividend,
  output logic [DATA_W-1:0] div_divisor,
  input  logic              div_busy,
  input  logic              div_done,
  input  logic [DATA_W-1:0] div_q,
  input  logic [DATA_W-1:0] div_r
);

  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_DIVU = 3'b010;
  localparam logic [2:0] OP_MTHI = 3'b011;
  localparam logic [2:0] OP_MTLO = 3'b100;
  localparam logic [2:0] OP_MFHI = 3'b101;
  localparam logic [2:0] OP_MFLO = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic              r_start;
  logic              r_signed;
  logic [DATA_W-1:0] r_dividend;
  logic [DATA_W-1:0] r_divisor;

  logic w_idle;
  logic w_hilo_op;
  logic w_is_div;
  logic w_done;

  assign w_idle    = (r_state == S_IDLE);
  assign w_hilo_op = (op_code != 3'b000) && (op_code != 3'b111);
  assign w_is_div  = (op_code == OP_DIV) || (op_code == OP_DIVU);
  // A genuine completion arrives only after the divider has dropped busy.
  assign w_done    = div_done & ~div_busy;

  assign stall = op_valid & ~w_idle & w_hilo_op;

  always_comb begin
    rd_val = '0;
    if (op_valid && w_idle) begin
      if (op_code == OP_MFHI)      rd_val = r_hi;
      else if (op_code == OP_MFLO) rd_val = r_lo;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_hi       <= '0;
      r_lo       <= '0;
      r_start    <= 1'b0;
      r_signed   <= 1'b0;
      r_dividend <= '0;
      r_divisor  <= '0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (op_valid) begin
            if (w_is_div && (rt_val != '0)) begin
              r_dividend <= rs_val;
              r_divisor  <= rt_val;
              r_signed   <= (op_code == OP_DIV);
              r_start    <= 1'b1;
              r_state    <= S_LAUNCH;
            end else if (op_code == OP_MTHI) begin
              r_hi <= rs_val;
            end else if (op_code == OP_MTLO) begin
              r_lo <= rs_val;
            end
          end
        end
        S_LAUNCH: begin
          r_state <= div_kill ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          if (w_done) begin
            if (!div_kill) begin
              r_lo <= div_q;
              r_hi <= div_r;
            end
            r_state <= S_IDLE;
          end else if (div_kill) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_done) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign hi           = r_hi;
  assign lo           = r_lo;
  assign div_start    = r_start;
  assign div_signed   = r_signed;
  assign div_dividend = r_dividend;
  assign div_divisor  = r_divisor;

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Directed bench for div_hilo_ctrl with a behavioural 32-cycle divider model.
module tb_div_hilo_ctrl;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_DIVU = 3'b010;
  localparam logic [2:0] OP_MTHI = 3'b011;
  localparam logic [2:0] OP_MTLO = 3'b100;
  localparam logic [2:0] OP_MFHI = 3'b101;
  localparam logic [2:0] OP_MFLO = 3'b110;

  logic        clock = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        div_kill;
  logic        stall;
  logic [31:0] rd_val;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_q;
  logic [31:0] div_r;

  int n_assert = 0;
  int n_fail   = 0;
  int n_stall;

  always #5 clock = ~clock;

  div_hilo_ctrl #(.DATA_W(32)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .rs_val(rs_val), .rt_val(rt_val), .div_kill(div_kill), .stall(stall),
    .rd_val(rd_val), .hi(hi), .lo(lo), .div_start(div_start),
    .div_signed(div_signed), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_busy(div_busy), .div_done(div_done),
    .div_q(div_q), .div_r(div_r)
  );

  // Divider model: busy 32 cycles after sampling start, done one cycle later.
  int div_cnt;
  always_ff @(posedge clock) begin
    if (reset) begin
      div_busy <= 1'b0;
      div_done <= 1'b0;
      div_cnt  <= 0;
    end else begin
      div_done <= 1'b0;
      if (!div_busy && div_start) begin
        div_busy <= 1'b1;
        div_cnt  <= 32;
      end else if (div_busy) begin
        if (div_cnt == 1) begin
          div_busy <= 1'b0;
          div_done <= 1'b1;
        end
        div_cnt <= div_cnt - 1;
      end
    end
  end

  always_comb begin
    div_q = '0;
    div_r = '0;
    if (div_divisor != '0) begin
      if (div_signed) begin
        div_q = 32'($signed(div_dividend) / $signed(div_divisor));
        div_r = 32'($signed(div_dividend) % $signed(div_divisor));
      end else begin
        div_q = div_dividend / div_divisor;
        div_r = div_dividend % div_divisor;
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    op_valid = v;
    op_code  = op;
    rs_val   = a;
    rt_val   = b;
  endtask

  // Present op until it is no longer stalled; returns the number of stalled cycles.
  task automatic wait_free(input logic [2:0] op, output int n);
    drive(1'b1, op, 32'h0, 32'h0);
    n = 0;
    #1;
    while (stall && n < 40) begin
      cyc();
      #1;
      n++;
    end
  endtask

  initial begin
    reset = 1'b1;
    div_kill = 1'b0;
    drive(1'b0, OP_NONE, 32'h0, 32'h0);
    cyc(); cyc();
    #1;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_start", 32'(div_start), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    reset = 1'b0;
    cyc();

    // Reads after reset
    drive(1'b1, OP_MFHI, 32'h0, 32'h0); #1;
    chk("mfhi0_rd", rd_val, 32'h0);
    chk("mfhi0_stall", 32'(stall), 32'h0);
    cyc();
    drive(1'b1, OP_MFLO, 32'h0, 32'h0); #1;
    chk("mflo0_rd", rd_val, 32'h0);
    chk("mflo0_stall", 32'(stall), 32'h0);
    cyc();

    // DIV 100/7 with a dependent MFLO held behind it
    drive(1'b1, OP_DIV, 32'd100, 32'd7); #1;
    chk("div1_stall", 32'(stall), 32'h0);
    cyc();
    drive(1'b1, OP_MFLO, 32'h0, 32'h0);
    for (int k = 1; k <= 34; k++) begin
      #1;
      chk($sformatf("div1_stall_t%0d", k), 32'(stall), 32'h1);
      chk($sformatf("div1_start_t%0d", k), 32'(div_start), 32'(k == 1));
      cyc();
    end
    #1;
    chk("div1_rel_stall", 32'(stall), 32'h0);
    chk("div1_mflo", rd_val, 32'd14);
    cyc();
    drive(1'b1, OP_MFHI, 32'h0, 32'h0); #1;
    chk("div1_mfhi", rd_val, 32'd2);
    cyc();

    // Signed -7/2
    drive(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2); #1;
    chk("sdiv_stall", 32'(stall), 32'h0);
    cyc();
    wait_free(OP_MFLO, n_stall);
    chk("sdiv_nstall", 32'(n_stall), 32'd34);
    chk("sdiv_mflo", rd_val, 32'hFFFF_FFFD);
    chk("sdiv_hi", hi, 32'hFFFF_FFFF);
    cyc();

    // Unsigned same operands
    drive(1'b1, OP_DIVU, 32'hFFFF_FFF9, 32'd2); #1;
    cyc();
    wait_free(OP_MFHI, n_stall);
    chk("udiv_nstall", 32'(n_stall), 32'd34);
    chk("udiv_mfhi", rd_val, 32'h1);
    chk("udiv_lo", lo, 32'h7FFF_FFFC);
    cyc();

    // MTHI then divide by zero
    drive(1'b1, OP_MTHI, 32'h1234, 32'h0); #1;
    chk("mthi_stall", 32'(stall), 32'h0);
    cyc();
    chk("mthi_hi", hi, 32'h1234);
    drive(1'b1, OP_DIV, 32'd55, 32'd0); #1;
    chk("dz_stall", 32'(stall), 32'h0);
    cyc();
    drive(1'b1, OP_MFHI, 32'h0, 32'h0); #1;
    chk("dz_start", 32'(div_start), 32'h0);
    chk("dz_stall2", 32'(stall), 32'h0);
    chk("dz_mfhi", rd_val, 32'h1234);
    chk("dz_lo", lo, 32'h7FFF_FFFC);
    cyc();

    // Killed divide: HI/LO keep prior values
    drive(1'b1, OP_DIV, 32'd100, 32'd7); #1;
    cyc();
    drive(1'b1, OP_MFLO, 32'h0, 32'h0);
    for (int k = 1; k <= 10; k++) begin
      div_kill = (k == 10);
      #1;
      chk($sformatf("kill_stall_t%0d", k), 32'(stall), 32'h1);
      cyc();
    end
    div_kill = 1'b0;
    wait_free(OP_MFLO, n_stall);
    chk("kill_nstall", 32'(n_stall), 32'd24);
    chk("kill_mflo", rd_val, 32'h7FFF_FFFC);
    chk("kill_hi", hi, 32'h1234);
    cyc();

    // Back-to-back divides
    drive(1'b1, OP_DIV, 32'd50, 32'd5); #1;
    chk("b2b_first_stall", 32'(stall), 32'h0);
    cyc();
    drive(1'b1, OP_DIV, 32'd9, 32'd2);
    wait_free(OP_DIV, n_stall);
    chk("b2b_nstall", 32'(n_stall), 32'd34);
    chk("b2b_mid_lo", lo, 32'd10);
    chk("b2b_mid_hi", hi, 32'd0);
    chk("b2b_accept_start", 32'(div_start), 32'h0);
    drive(1'b1, OP_DIV, 32'd9, 32'd2);
    cyc();
    drive(1'b0, OP_NONE, 32'h0, 32'h0); #1;
    chk("b2b_start", 32'(div_start), 32'h1);
    cyc();
    wait_free(OP_MFLO, n_stall);
    chk("b2b_nstall2", 32'(n_stall), 32'd33);
    chk("b2b_mflo", rd_val, 32'd4);
    chk("b2b_hi", hi, 32'd1);
    cyc();

    // Reset mid-divide
    drive(1'b1, OP_DIV, 32'd100, 32'd7); #1;
    cyc();
    drive(1'b0, OP_NONE, 32'h0, 32'h0);
    repeat (19) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    drive(1'b1, OP_MFLO, 32'h0, 32'h0); #1;
    chk("mrst_stall", 32'(stall), 32'h0);
    chk("mrst_hi", hi, 32'h0);
    chk("mrst_lo", lo, 32'h0);
    chk("mrst_rd", rd_val, 32'h0);
    chk("mrst_start", 32'(div_start), 32'h0);
    cyc();
    drive(1'b1, OP_MTLO, 32'h5A5A, 32'h0); #1;
    chk("mrst_mtlo_stall", 32'(stall), 32'h0);
    cyc();
    drive(1'b1, OP_MFLO, 32'h0, 32'h0); #1;
    chk("mrst_mflo", rd_val, 32'h5A5A);
    cyc();
    drive(1'b0, OP_NONE, 32'h0, 32'h0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/div_hilo_ctrl.md
Name: div_hilo_ctrl

Overview:
- Sequences the shared iterative divider for DIV/DIVU in the MIPS-54 dynamic pipeline.
- Owns the architectural HI/LO registers and services MTHI/MTLO/MFHI/MFLO.
- Raises a pipeline stall when a HI/LO consumer or a second divide arrives while a divide is in flight.
- Sits beside the EX stage: the EX stage drives its op inputs, and its div_* ports connect to the divider instance.

Parameters:
- DATA_W, 32, operand and HI/LO width. Only 32 is supported.

Ports:
- clock  in  1  clock
- reset  in  1  reset; synchronous, active-high
- op_valid  in  1  EX-stage op present this cycle
- op_code  in  3  000 none, 001 DIV, 010 DIVU, 011 MTHI, 100 MTLO, 101 MFHI, 110 MFLO, 111 reserved (treated as none)
- rs_val  in  32  dividend, or MTHI/MTLO source
- rt_val  in  32  divisor
- div_kill  in  1  in-flight divide squashed by the pipeline; result must be discarded
- stall  out  1  hold EX and earlier stages (combinational)
- rd_val  out  32  MFHI/MFLO read data (combinational); 0 otherwise
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- div_start  out  1  divider launch, registered, one-cycle pulse
- div_signed  out  1  1 = signed divide
- div_dividend  out  32  to divider
- div_divisor  out  32  to divider
- div_busy  in  1  divider busy
- div_done  in  1  one-cycle pulse the cycle after div_busy falls
- div_q  in  32  quotient; valid at div_done
- div_r  in  32  remainder; valid at div_done

Behaviour:
Divider contract:
- The divider samples div_start when div_busy=0.
- div_busy rises on the next cycle and stays high 32 cycles.
- div_done pulses the cycle after div_busy falls.
- div_q/div_r are combinational on the operand inputs, so div_dividend/div_divisor/div_signed come from internal registers and stay stable from LAUNCH until div_done.

Reset:
- state=IDLE; hi=lo=0; div_start=0; operand registers=0; stall=0.
- Reset mid-divide returns to IDLE immediately. The divider is reset by the same signal.

States:
- IDLE, accepting ops:
  - DIV/DIVU with rt_val!=0: latch rs_val, rt_val and signedness (DIV=1) -> LAUNCH; stall=0, the op retires.
  - DIV/DIVU with rt_val==0: no launch; HI/LO unchanged; remain IDLE; stall=0.
  - MTHI/MTLO: write hi/lo at the clock edge; visible the next cycle.
  - MFHI/MFLO: rd_val=hi/lo in the same cycle; stall=0.
- LAUNCH: div_start=1 for exactly this cycle -> WAIT. If div_kill: -> DRAIN. div_start still issues.
- WAIT:
  - On div_done: lo<=div_q, hi<=div_r, -> IDLE.
  - On div_kill without div_done: -> DRAIN.
  - div_kill and div_done in the same cycle: discard the result, -> IDLE.
- DRAIN: on div_done, discard the result, -> IDLE.

Stall:
- stall = op_valid & (state!=IDLE) & op_code in {DIV, DIVU, MTHI, MTLO, MFHI, MFLO}.
- A stalled op is re-presented unchanged by the pipeline. No state update occurs from a stalled op.
- There is no forwarding of div_q/div_r: a stalled consumer completes on the first IDLE cycle.

Timing:
- DIV accepted in cycle T: div_start in T+1, div_busy T+2..T+33, div_done T+34, hi/lo updated at the end of T+34.
- A dependent MFLO stalls through T+34 and completes in T+35.

Arithmetic:
- No special-casing in the controller. 0x80000000 / -1 returns whatever the divider produces.
- Signed remainder follows the dividend sign, as produced by the divider.

Protocol error:
- div_done in IDLE or LAUNCH is ignored.

Test Plan:
- Reset, then MFHI and MFLO -> rd_val=0, stall=0; hi=lo=0.
- DIV rs=100, rt=7 at T; MFLO held from T+1 -> stall=1 T+1..T+34, div_start only in T+1, rd_val=14 at T+35. MFHI then yields 2.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU same operands -> lo=0x7FFFFFFC, hi=1.
- MTHI 0x1234, then DIV rt=0 -> no div_start, stall=0; next MFHI=0x1234.
- DIV 100/7, div_kill at T+10 -> state DRAIN; at div_done hi/lo keep prior values; a stalled MFLO is released at T+35 with the old lo.
- Back-to-back DIV 50/5 then DIV 9/2 -> second DIV stalls until IDLE; the second div_start goes out one cycle after it is accepted; final lo=4, hi=1.
- Reset asserted at T+20 of a divide -> next cycle state IDLE, hi=lo=0, stall=0.
